// File: rtl/lbp_gen.sv
// Local binary pattern generator: walks a gray image in raster order, writes a
// zero code for border pixels and an 8-bit LBP code for interior pixels.
//
// state  | meaning
// IDLE   | waiting for the first cycle with gray_ready=1
// BORDER | writing 0x00 for a border pixel, one per cycle
// FETCH  | reading window pixels (9 at col 1, 3 afterwards)
// WRITE  | writing the interior LBP code from the held 3x3 window
// DONE   | frame complete, finish held until reset
module lbp_gen #(
   parameter int IMG_W = 128,
   parameter int IMG_H = 128,
   parameter int AW    = 14
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    cfg_thr,
   input  logic          gray_ready,
   output logic          gray_req,
   output logic [AW-1:0] gray_addr,
   input  logic [7:0]    gray_data,
   output logic          lbp_valid,
   output logic [AW-1:0] lbp_addr,
   output logic [7:0]    lbp_data,
   output logic          finish
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [AW-1:0] LAST = AW'(IMG_W*IMG_H-1);
   localparam logic [AW-1:0] W1   = AW'(IMG_W);
   localparam logic [AW-1:0] W2   = AW'(2*IMG_W);

   typedef enum logic [2:0] {IDLE, BORDER, FETCH, WRITE, DONE} state_t;

   state_t        state;
   logic [CW-1:0] col, nxt_col;
   logic [RW-1:0] row, nxt_row;
   logic [AW-1:0] addr;
   logic [1:0]    frow, fcol;
   logic [7:0]    thr_q;
   logic [7:0]    win [0:2][0:2];
   logic          done_q;

   logic          nxt_interior, last_read, active;
   logic [AW-1:0] roff, rd_addr;
   logic [8:0]    gc9;
   logic [7:0]    code;

   always_comb begin
      nxt_col      = (col == CW'(IMG_W-1)) ? '0 : col + 1'b1;
      nxt_row      = (col == CW'(IMG_W-1)) ? row + 1'b1 : row;
      nxt_interior = (nxt_row != '0) && (nxt_row != RW'(IMG_H-1)) &&
                     (nxt_col != '0) && (nxt_col != CW'(IMG_W-1));
      last_read    = (frow == 2'd2) && (fcol == 2'd2);
      roff         = (frow == 2'd0) ? '0 : (frow == 2'd1) ? W1 : W2;
      // window origin is (row-1, col-1); frow/fcol select the tap being read
      rd_addr      = addr - W1 - AW'(1) + roff + AW'(fcol);
      // 9-bit sum so a bright center plus threshold never wraps
      gc9          = {1'b0, win[1][1]} + {1'b0, thr_q};
      code[0]      = {1'b0, win[0][0]} >= gc9;
      code[1]      = {1'b0, win[0][1]} >= gc9;
      code[2]      = {1'b0, win[0][2]} >= gc9;
      code[3]      = {1'b0, win[1][0]} >= gc9;
      code[4]      = {1'b0, win[1][2]} >= gc9;
      code[5]      = {1'b0, win[2][0]} >= gc9;
      code[6]      = {1'b0, win[2][1]} >= gc9;
      code[7]      = {1'b0, win[2][2]} >= gc9;
   end

   assign active    = !reset && gray_ready;
   assign gray_req  = active && (state == FETCH);
   assign gray_addr = gray_req ? rd_addr : '0;
   assign lbp_valid = active && ((state == BORDER) || (state == WRITE));
   assign lbp_addr  = reset ? '0 : addr;
   assign lbp_data  = (lbp_valid && (state == WRITE)) ? code : '0;
   assign finish    = done_q && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         col    <= '0;
         row    <= '0;
         addr   <= '0;
         frow   <= '0;
         fcol   <= '0;
         thr_q  <= '0;
         done_q <= 1'b0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win[r][c] <= '0;
      end else begin
         case (state)
            IDLE: if (gray_ready) begin
               state <= BORDER;
               thr_q <= cfg_thr;
               addr  <= '0;
               row   <= '0;
               col   <= '0;
            end
            BORDER, WRITE: if (gray_ready) begin
               if (addr == LAST) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end else begin
                  addr <= addr + 1'b1;
                  col  <= nxt_col;
                  row  <= nxt_row;
                  if (nxt_interior) begin
                     state <= FETCH;
                     frow  <= 2'd0;
                     if (state == WRITE) begin
                        // slide right: keep two columns, fetch only the new one
                        fcol <= 2'd2;
                        for (int r = 0; r < 3; r++) begin
                           win[r][0] <= win[r][1];
                           win[r][1] <= win[r][2];
                        end
                     end else begin
                        fcol <= 2'd0;
                     end
                  end else begin
                     state <= BORDER;
                  end
               end
            end
            FETCH: if (gray_ready) begin
               win[frow][fcol] <= gray_data;
               if (last_read) begin
                  state <= WRITE;
               end else if (frow == 2'd2) begin
                  frow <= 2'd0;
                  fcol <= fcol + 2'd1;
               end else begin
                  frow <= frow + 2'd1;
               end
            end
            DONE: ;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
